// File: rtl/asm_pkg.sv
// Shared definitions for the binarised ternary MAC array: FSM encoding,
// the ternary zero pixel code and a constant clog2 helper.
package asm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01
    } state_t;

    localparam logic [1:0] PIX_ZERO = 2'b10;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/asm_if.sv
// Stream, threshold and status signals between a pixel/weight source and asm_array.
interface asm_if #(
    parameter int LANES = 8,
    parameter int BN_W  = 16
) ();

    logic                    calculate_en;
    logic [2*LANES-1:0]      data_pix;
    logic [LANES-1:0]        data_weight;
    logic                    in_valid;
    logic                    in_last;
    logic signed [BN_W-1:0]  data_bn;
    logic                    bn_load;
    logic                    data_out;
    logic                    out_valid;
    logic                    sat_flag;

    modport master (
        output calculate_en, data_pix, data_weight, in_valid, in_last, data_bn, bn_load,
        input  data_out, out_valid, sat_flag
    );

    modport slave (
        input  calculate_en, data_pix, data_weight, in_valid, in_last, data_bn, bn_load,
        output data_out, out_valid, sat_flag
    );

endinterface

// File: rtl/asm_lane_sum.sv
// Combinational ternary products of all lanes reduced to one signed partial sum.
module asm_lane_sum
    import asm_pkg::*;
#(
    parameter int LANES = 8,
    parameter int PS_W  = clog2(LANES + 1) + 1
) (
    input  logic [2*LANES-1:0]     i_pix,
    input  logic [LANES-1:0]       i_weight,
    output logic signed [PS_W-1:0] o_partial
);

    localparam logic signed [PS_W-1:0] ONE = PS_W'(1);

    logic signed [PS_W-1:0] w_prod [LANES];

    // Zero code wins over the sign rule; otherwise a weight/pix[0] mismatch gives -1.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (i_pix[2*i +: 2] == PIX_ZERO)
                w_prod[i] = '0;
            else if (i_weight[i] ^ i_pix[2*i])
                w_prod[i] = -ONE;
            else
                w_prod[i] = ONE;
        end
    end

    always_comb begin
        o_partial = '0;
        for (int i = 0; i < LANES; i++) begin
            o_partial = o_partial + w_prod[i];
        end
    end

endmodule

// File: rtl/asm_array.sv
// Windowed saturating accumulator of ternary partial sums, binarised against
// a loadable signed threshold at the end of each window.
module asm_array
    import asm_pkg::*;
#(
    parameter int LANES = 8,
    parameter int ACC_W = 12,
    parameter int BN_W  = 16
) (
    input  logic clk,
    input  logic rst,
    asm_if.slave bus
);

    localparam int PS_W  = clog2(LANES + 1) + 1;
    localparam int SUM_W = ((ACC_W > PS_W) ? ACC_W : PS_W) + 1;
    localparam int CMP_W = (ACC_W > BN_W) ? ACC_W : BN_W;

    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 <<< (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(1 <<< (ACC_W - 1)));

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [BN_W-1:0]  r_thr;
    logic                    r_data_out;
    logic                    r_out_valid;
    logic                    r_sat;

    logic signed [PS_W-1:0]  w_partial;
    logic signed [SUM_W-1:0] w_sum;
    logic                    w_clamp_hi;
    logic                    w_clamp_lo;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_gt;

    asm_lane_sum #(
        .LANES (LANES),
        .PS_W  (PS_W)
    ) u_lane_sum (
        .i_pix     (bus.data_pix),
        .i_weight  (bus.data_weight),
        .o_partial (w_partial)
    );

    assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_partial);
    assign w_clamp_hi = (w_sum > ACC_MAX);
    assign w_clamp_lo = (w_sum < ACC_MIN);
    assign w_acc_next = w_clamp_hi ? ACC_MAX[ACC_W-1:0] :
                        w_clamp_lo ? ACC_MIN[ACC_W-1:0] : w_sum[ACC_W-1:0];
    // Old threshold is used here even if bn_load is asserted on the same beat.
    assign w_gt       = (CMP_W'(w_acc_next) > CMP_W'(r_thr));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_thr       <= '0;
            r_data_out  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_acc       <= '0;
                    r_thr       <= '0;
                    r_out_valid <= 1'b0;
                    r_sat       <= 1'b0;
                    if (bus.calculate_en) r_state <= ST_CALC;
                end
                ST_CALC: begin
                    r_out_valid <= 1'b0;
                    if (!bus.calculate_en) begin
                        // Partial window is dropped without a result.
                        r_state <= ST_IDLE;
                        r_acc   <= '0;
                    end else begin
                        if (bus.bn_load) r_thr <= bus.data_bn;
                        if (bus.in_valid) begin
                            if (w_clamp_hi || w_clamp_lo) r_sat <= 1'b1;
                            if (bus.in_last) begin
                                r_data_out  <= w_gt;
                                r_out_valid <= 1'b1;
                                r_acc       <= '0;
                            end else begin
                                r_acc <= w_acc_next;
                            end
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.out_valid = r_out_valid;
    assign bus.sat_flag  = r_sat;

endmodule

// File: tb/tb_asm_array.sv
// Directed self-checking bench for asm_array with LANES=4, ACC_W=8, BN_W=16.
module tb_asm_array;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    localparam logic [7:0] PIX_ONES = 8'b01010101;
    localparam logic [7:0] PIX_P1   = 8'b10101001;
    localparam logic [7:0] PIX_ZERO = 8'b10101010;

    asm_if #(.LANES(4), .BN_W(16)) bus ();

    asm_array #(.LANES(4), .ACC_W(8), .BN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] pix, input logic [3:0] w, input logic last);
        bus.in_valid    = 1'b1;
        bus.in_last     = last;
        bus.data_pix    = pix;
        bus.data_weight = w;
        tick();
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
    endtask

    task automatic load(input logic signed [15:0] thr);
        bus.bn_load = 1'b1;
        bus.data_bn = thr;
        tick();
        bus.bn_load = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        bus.calculate_en = 1'b0;
        bus.data_pix     = '0;
        bus.data_weight  = '0;
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.data_bn      = '0;
        bus.bn_load      = 1'b0;
        tick();
        tick();
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sat", bus.sat_flag, 0);

        rst = 1'b0;
        bus.calculate_en = 1'b1;
        tick();

        // +4 single-beat window against thr=0
        bus.data_pix = PIX_ONES;
        bus.data_weight = 4'b1111;
        #1;
        chk("partial_p4", dut.w_partial, 4);
        bus.data_weight = 4'b0000;
        #1;
        chk("partial_n4", dut.w_partial, -4);
        bus.data_pix = PIX_P1;
        bus.data_weight = 4'b0001;
        #1;
        chk("partial_p1", dut.w_partial, 1);
        beat(PIX_ONES, 4'b1111, 1'b1);
        chk("w1_out_valid", bus.out_valid, 1);
        chk("w1_data_out", bus.data_out, 1);
        tick();
        chk("w1_pulse_end", bus.out_valid, 0);

        // 4 + 1 = 5 against thr=5 (false) then thr=4 (true); stray in_last without valid
        load(16'sd5);
        beat(PIX_ONES, 4'b1111, 1'b0);
        chk("w2_mid_no_valid", bus.out_valid, 0);
        bus.in_last = 1'b1;
        tick();
        bus.in_last = 1'b0;
        chk("w2_last_ignored", bus.out_valid, 0);
        beat(PIX_P1, 4'b0001, 1'b1);
        chk("w2_out_valid", bus.out_valid, 1);
        chk("w2_eq_thr", bus.data_out, 0);
        load(16'sd4);
        beat(PIX_ONES, 4'b1111, 1'b0);
        beat(PIX_P1, 4'b0001, 1'b1);
        chk("w3_gt_thr", bus.data_out, 1);

        // thr=-1: -4 gives 0, ten zero beats give 1 with no saturation
        load(-16'sd1);
        beat(PIX_ONES, 4'b0000, 1'b1);
        chk("w4_neg", bus.data_out, 0);
        for (int i = 1; i <= 10; i++) beat(PIX_ZERO, 4'b0000, (i == 10));
        chk("w5_out_valid", bus.out_valid, 1);
        chk("w5_zero_gt_m1", bus.data_out, 1);
        chk("w5_sat", bus.sat_flag, 0);

        // 40 beats of -4: reaches -128 at beat 32, clamps from beat 33
        load(-16'sd128);
        for (int i = 1; i <= 40; i++) begin
            beat(PIX_ONES, 4'b0000, (i == 40));
            if (i == 32) chk("w6_sat_at_min", bus.sat_flag, 0);
            if (i == 33) chk("w6_sat_set", bus.sat_flag, 1);
        end
        chk("w6_out_valid", bus.out_valid, 1);
        chk("w6_eq_min", bus.data_out, 0);
        chk("w6_sat_sticky", bus.sat_flag, 1);

        // Drop enable after 3 beats of -4; the last beat coinciding with the drop is discarded
        for (int i = 0; i < 3; i++) beat(PIX_ONES, 4'b0000, 1'b0);
        bus.calculate_en = 1'b0;
        beat(PIX_ONES, 4'b0000, 1'b1);
        chk("drop_no_valid", bus.out_valid, 0);
        tick();
        chk("idle_sat_clr", bus.sat_flag, 0);
        chk("idle_hold_out", bus.data_out, 0);
        bus.calculate_en = 1'b1;
        tick();
        load(16'sd7);
        beat(PIX_ONES, 4'b1111, 1'b0);
        chk("w7_mid", bus.out_valid, 0);
        beat(PIX_ONES, 4'b1111, 1'b1);
        chk("w7_out_valid", bus.out_valid, 1);
        chk("w7_acc_cleared", bus.data_out, 1);
        tick();
        chk("w7_single_pulse", bus.out_valid, 0);

        // bn_load coincident with last: compare uses old thr=2, next window uses 3
        load(16'sd2);
        beat(PIX_P1, 4'b0001, 1'b0);
        beat(PIX_P1, 4'b0001, 1'b0);
        bus.bn_load = 1'b1;
        bus.data_bn = 16'sd3;
        beat(PIX_P1, 4'b0001, 1'b1);
        bus.bn_load = 1'b0;
        chk("w8_old_thr", bus.data_out, 1);
        for (int i = 1; i <= 3; i++) beat(PIX_P1, 4'b0001, (i == 3));
        chk("w9_new_thr", bus.data_out, 0);

        // Back-to-back single-beat windows against thr=3
        beat(PIX_ONES, 4'b1111, 1'b1);
        chk("b2b_v1", bus.out_valid, 1);
        chk("b2b_d1", bus.data_out, 1);
        beat(PIX_ONES, 4'b0000, 1'b1);
        chk("b2b_v2", bus.out_valid, 1);
        chk("b2b_d2", bus.data_out, 0);
        beat(PIX_ONES, 4'b1111, 1'b1);
        chk("b2b_v3", bus.out_valid, 1);
        chk("b2b_d3", bus.data_out, 1);

        // Reset overrides a last beat mid-window
        beat(PIX_ONES, 4'b1111, 1'b0);
        rst = 1'b1;
        beat(PIX_ONES, 4'b1111, 1'b1);
        rst = 1'b0;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_data", bus.data_out, 0);

        // bn_load in IDLE is ignored: -1 compared against thr=0
        bus.calculate_en = 1'b0;
        tick();
        load(-16'sd5);
        bus.calculate_en = 1'b1;
        tick();
        bus.data_pix = PIX_P1;
        bus.data_weight = 4'b0000;
        #1;
        chk("partial_m1", dut.w_partial, -1);
        beat(PIX_P1, 4'b0000, 1'b1);
        chk("idle_load_v", bus.out_valid, 1);
        chk("idle_load_ignored", bus.data_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/asm_array.md
ASM_ARRAY -- requirements
Module: asm_array

Interface
REQ-001 The block SHALL have parameter LANES, default 8, giving the number of pixel/weight pairs consumed per cycle.
REQ-002 The block SHALL have parameter ACC_W, default 12, giving the signed accumulator width.
REQ-003 The block SHALL have parameter BN_W, default 16, giving the signed BN threshold width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-006 The block SHALL have port calculate_en, input, 1 bit, which enables the block; low forces IDLE.
REQ-007 The block SHALL have port data_pix, input, 2*LANES bits, with lane i in bits [2i+1:2i].
REQ-008 The block SHALL have port data_weight, input, LANES bits, holding one binary weight per lane.
REQ-009 The block SHALL have port in_valid, input, 1 bit, which qualifies data_pix and data_weight.
REQ-010 The block SHALL have port in_last, input, 1 bit, marking the last beat of a window; it is only meaningful with in_valid.
REQ-011 The block SHALL have port data_bn, input, BN_W bits, the signed threshold value.
REQ-012 The block SHALL have port bn_load, input, 1 bit, which latches data_bn into the threshold register.
REQ-013 The block SHALL have port data_out, output, 1 bit, the binarised activation of the last completed window.
REQ-014 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse when data_out updates.
REQ-015 The block SHALL have port sat_flag, output, 1 bit, a sticky flag set when any accumulator saturated.

Function
REQ-016 The block SHALL compute each lane's product as 0 when pix==2'b10, else -1 when (weight XOR pix[0]) is 1, else +1.
REQ-017 The block SHALL form the per-cycle partial sum as the signed sum of all LANES products, width clog2(LANES+1)+1.
REQ-018 The block SHALL implement FSM states IDLE and CALC: IDLE->CALC when calculate_en=1, CALC->IDLE when calculate_en=0, and any other encoding->IDLE.
REQ-019 In IDLE, the block SHALL clear acc, the threshold register, out_valid and sat_flag to 0, and hold data_out.
REQ-020 In CALC with in_valid=1 and in_last=0, the block SHALL set acc <= sat(acc + partial).
REQ-021 In CALC with in_valid=1 and in_last=1, the block SHALL set data_out <= (sat(acc+partial) > thr), out_valid <= 1 and acc <= 0, so the next window starts in the following cycle with no bubble.
REQ-022 When in_valid=0, the block SHALL hold acc, and in_last SHALL be ignored.
REQ-023 out_valid SHALL be high for exactly one cycle, one cycle after the in_last beat, and SHALL be 0 otherwise.
REQ-024 The comparison SHALL be signed and strict (>), with acc sign-extended to max(ACC_W,BN_W).
REQ-025 Saturation SHALL clamp to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1], and any clamp event SHALL set sat_flag until rst or IDLE.
REQ-026 bn_load SHALL take effect on the next cycle; when bn_load and in_last coincide, the compare SHALL use the old thr.
REQ-027 bn_load SHALL be honoured only in CALC.
REQ-028 When calculate_en drops mid-window, the block SHALL discard the partial window and SHALL NOT produce an out_valid pulse.
REQ-029 Back-to-back in_last beats (1-beat windows) SHALL each produce one out_valid pulse.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL enter IDLE with acc=0, thr=0, data_out=0, out_valid=0 and sat_flag=0.
REQ-031 rst SHALL override every other input, including mid-window.

Structure
REQ-032 Package asm_pkg SHALL hold the FSM state encoding (IDLE, CALC), the ternary zero code 2'b10 and a clog2 helper constant function.
REQ-033 The block SHALL contain one sub-module, asm_lane_sum, a purely combinational LANES-wide ternary product and adder tree producing the partial sum.
REQ-034 All state SHALL be held in the top-level asm_array.

Verification (LANES=4, ACC_W=8, BN_W=16)
REQ-035 With thr=0, one beat of pix=all 2'b01, weight=4'b1111 and in_last -> partial=+4, and data_out=1 with out_valid pulsed on the next cycle.
REQ-036 With thr=5, beats of +4 then +1 (last) -> acc=5, 5>5 false, data_out=0; with thr=4 -> data_out=1.
REQ-037 With all lanes pix=2'b10 for 10 beats, last on beat 10, thr=-1 -> acc=0, data_out=1, and sat_flag=0.
REQ-038 With 40 beats of -4, last on beat 40 -> acc clamps to -128, sat_flag=1, and data_out=0 for thr=-128.
REQ-039 When calculate_en drops after 3 beats and then rises, a new 2-beat window of +4 each with thr=7 -> out_valid occurs once and data_out=1, proving acc was cleared.
REQ-040 With bn_load(data_bn=3) in the same cycle as in_last at acc=3 and old thr=2 -> data_out=1, and the next window compares against 3.
